cache_refill_ctrl: RTL and testbench

Memory-side refill engine for the direct-mapped instruction/data cache. When the cache reports a miss, it fetches the missing 16-byte line from main memory as four sequential 32-bit word reads. It assembles them into a 128-bit line and delivers it to the cache together with the line base address. It sits between the cache miss path and the main-memory word port, and enforces a per-word acknowledge timeout.

---
 rtl/cache_refill_ctrl_if.sv | 35 +++
 rtl/cache_refill_ctrl.sv | 159 +++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_ctrl_if.sv
// cache_refill_ctrl_if
//   Bundles the cache miss path, the main-memory word port and the line
//   delivery outputs of the refill engine.
//   modport master : refill engine side (issues memory requests, delivers lines)
//   modport slave  : environment side (cache miss source + main memory)
//
//   miss_req/miss_addr   cache -> engine   miss strobe and missing byte address
//   busy                 engine -> cache   refill in progress
//   mem_req/mem_addr     engine -> memory  word read request, word address
//   mem_ack/mem_rdata    memory -> engine  accept + read data (same cycle)
//   line_valid/line_addr/data_line  engine -> cache  completed line
//   err                  engine -> cache   refill aborted by ack timeout
interface cache_refill_ctrl_if;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         busy;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         line_valid;
  logic [31:0]  line_addr;
  logic [127:0] data_line;
  logic         err;

  modport master (
    input  miss_req, miss_addr, mem_ack, mem_rdata,
    output busy, mem_req, mem_addr, line_valid, line_addr, data_line, err
  );

  modport slave (
    output miss_req, miss_addr, mem_ack, mem_rdata,
    input  busy, mem_req, mem_addr, line_valid, line_addr, data_line, err
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Fetches a missing 16-byte cache line as four ascending 32-bit word reads,
//   assembles it into a 128-bit line and hands it to the cache with its base
//   address. Each word request is aborted if mem_ack does not arrive within
//   TIMEOUT_CYCLES cycles.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    cache_refill_ctrl_if.master (miss path, memory port, line output)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for miss_req; busy=0, mem_req=0
//   FETCH | requesting word k of the line, waiting for mem_ack
//   DONE  | line_valid pulse; data_line/line_addr were loaded on entry
//   ABORT | err pulse after an ack timeout; line outputs untouched
module cache_refill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_refill_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE, ABORT} state_e;

  // Timeout is a down-counter reloaded at the start of every word; reaching
  // terminal count 1 on a cycle without ack means TIMEOUT_CYCLES ack-less
  // cycles have elapsed for this word.
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [27:0]       base_q, base_d;
  logic [1:0]        k_q, k_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [3:0][31:0]  stage_q, stage_d;

  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              line_valid_q, line_valid_d;
  logic              err_q, err_d;
  logic [31:0]       line_addr_q, line_addr_d;
  logic [127:0]      data_line_q, data_line_d;

  logic              xfer;

  // Byte-offset bits of the miss address do not matter: the whole line is fetched.
  logic unused_offset_bits;
  assign unused_offset_bits = ^bus.miss_addr[3:0];

  // mem_req is registered, so an ack while idle never counts as a transfer.
  assign xfer = mem_req_q && bus.mem_ack;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    k_d          = k_q;
    tmo_d        = tmo_q;
    stage_d      = stage_q;
    busy_d       = busy_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    line_valid_d = 1'b0;
    err_d        = 1'b0;
    line_addr_d  = line_addr_q;
    data_line_d  = data_line_q;

    unique case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          state_d    = FETCH;
          base_d     = bus.miss_addr[31:4];
          k_d        = 2'd0;
          tmo_d      = TMO_LOAD;
          busy_d     = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = {bus.miss_addr[31:4], 4'h0};
        end
      end

      FETCH: begin
        if (xfer) begin
          stage_d[k_q] = bus.mem_rdata;
          tmo_d        = TMO_LOAD;
          k_d          = k_q + 2'd1;
          if (k_q == 2'd3) begin
            // Load the line outputs on the DONE transition, including the
            // word arriving this cycle, so they change exactly once.
            state_d      = DONE;
            mem_req_d    = 1'b0;
            line_valid_d = 1'b1;
            line_addr_d  = {base_q, 4'h0};
            data_line_d  = stage_d;
          end else begin
            mem_addr_d = {base_q, k_d, 2'b00};
          end
        end else if (tmo_q <= 8'd1) begin
          state_d   = ABORT;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end

      DONE, ABORT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      k_q          <= '0;
      tmo_q        <= '0;
      stage_q      <= '0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      line_valid_q <= 1'b0;
      err_q        <= 1'b0;
      line_addr_q  <= '0;
      data_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      k_q          <= k_d;
      tmo_q        <= tmo_d;
      stage_q      <= stage_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      line_valid_q <= line_valid_d;
      err_q        <= err_d;
      line_addr_q  <= line_addr_d;
      data_line_q  <= data_line_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.line_valid = line_valid_q;
  assign bus.err        = err_q;
  assign bus.line_addr  = line_addr_q;
  assign bus.data_line  = data_line_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: table of refill vectors plus hand-written
// reset/stray-ack sequences. A memory responder answers word requests and
// checks the request address sequence; expected lines go through a queue.
module tb_cache_refill_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;

  cache_refill_ctrl_if bus ();

  cache_refill_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // responder configuration, set by the main sequence
  logic [31:0] seed       = 32'h0;
  int          ack_period = 1;
  bit          stall_en   = 1'b0;
  bit          stray_ack  = 1'b0;
  logic [31:0] exp_base   = 32'h0;
  int          exp_k      = 0;

  typedef struct {
    logic [31:0]  line_addr;
    logic [127:0] data;
  } line_t;
  line_t sb_q[$];

  typedef struct {
    string        name;
    logic [31:0]  addr;
    logic [31:0]  seed;
    int           period;
    bit           inject;
    bit           is_timeout;
    int           exp_lat;
    logic [31:0]  exp_line_addr;
    logic [127:0] exp_data;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory model: word = seed + word index; acks every ack_period-th cycle of
  // a request; with stall_en word 2 is never acked.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        chk("mem_addr", bus.mem_addr, exp_base + 32'(exp_k * 4));
        bus.mem_rdata = seed + {30'd0, bus.mem_addr[3:2]};
        if (stall_en && bus.mem_addr[3:2] == 2'd2) begin
          bus.mem_ack = 1'b0;
        end else if (wcnt == ack_period - 1) begin
          bus.mem_ack = 1'b1;
          wcnt = 0;
          exp_k++;
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.mem_ack   = stray_ack;
        bus.mem_rdata = 32'hDEAD_BEEF;
        wcnt = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   start;
    int   n;
    bit   seen;
    line_t e;
    @(negedge clk);
    seed       = v.seed;
    ack_period = v.period;
    stall_en   = v.is_timeout;
    exp_base   = {v.addr[31:4], 4'h0};
    exp_k      = 0;
    if (!v.is_timeout) sb_q.push_back('{v.exp_line_addr, v.exp_data});
    bus.miss_req  = 1'b1;
    bus.miss_addr = v.addr;
    start = cyc;
    @(negedge clk);
    bus.miss_req = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      if (bus.line_valid || bus.err) begin
        seen = 1'b1;
        chk({v.name, " latency"}, 128'(cyc - start), 128'(v.exp_lat));
        chk({v.name, " mem_req_low"}, bus.mem_req, 1'b0);
        chk({v.name, " busy_in_end"}, bus.busy, 1'b1);
        if (v.is_timeout) begin
          chk({v.name, " err"}, bus.err, 1'b1);
          chk({v.name, " no_line_valid"}, bus.line_valid, 1'b0);
          chk({v.name, " words_before_abort"}, 128'(exp_k), 128'd2);
          chk({v.name, " line_addr_kept"}, bus.line_addr, v.exp_line_addr);
          chk({v.name, " data_line_kept"}, bus.data_line, v.exp_data);
        end else begin
          chk({v.name, " no_err"}, bus.err, 1'b0);
          chk({v.name, " words"}, 128'(exp_k), 128'd4);
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: line_valid with no expected line queued", v.name);
          end else begin
            e = sb_q.pop_front();
            chk({v.name, " line_addr"}, bus.line_addr, e.line_addr);
            chk({v.name, " data_line"}, bus.data_line, e.data);
          end
        end
      end else begin
        chk({v.name, " busy_hold"}, bus.busy, 1'b1);
        if (v.inject && (cyc - start) == 2) begin
          bus.miss_req  = 1'b1;
          bus.miss_addr = 32'hFFFF_FFF0;
        end else begin
          bus.miss_req = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    bus.miss_req = 1'b0;
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no line_valid/err within 40 cycles", v.name);
      sb_q.delete();
    end
    repeat (3) begin
      @(negedge clk);
      chk({v.name, " idle_busy"}, bus.busy, 1'b0);
      chk({v.name, " idle_mem_req"}, bus.mem_req, 1'b0);
      chk({v.name, " pulse_width"}, {bus.line_valid, bus.err}, 2'b00);
    end
  endtask

  vec_t vecs[6];
  vec_t post_rst;

  initial begin
    vecs[0] = '{"zero_wait", 32'h0000_1238, 32'h0000_00A0, 1, 1'b0, 1'b0, 5,
                32'h0000_1230, 128'h000000A3_000000A2_000000A1_000000A0};
    vecs[1] = '{"wait3", 32'h0000_1238, 32'h0000_00A0, 3, 1'b0, 1'b0, 13,
                32'h0000_1230, 128'h000000A3_000000A2_000000A1_000000A0};
    vecs[2] = '{"ignored_miss", 32'h0000_5554, 32'h1000_0000, 1, 1'b1, 1'b0, 5,
                32'h0000_5550, 128'h10000003_10000002_10000001_10000000};
    vecs[3] = '{"wait2", 32'h0000_0ABC, 32'hCAFE_0000, 2, 1'b0, 1'b0, 9,
                32'h0000_0AB0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000};
    vecs[4] = '{"timeout", 32'h0000_2000, 32'h0000_0011, 1, 1'b0, 1'b1, 7,
                32'h0000_0AB0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000};
    vecs[5] = '{"after_timeout", 32'hFFFF_FFFC, 32'h7000_0000, 1, 1'b0, 1'b0, 5,
                32'hFFFF_FFF0, 128'h70000003_70000002_70000001_70000000};
    post_rst = '{"post_reset", 32'h0000_0040, 32'h4000_0000, 1, 1'b0, 1'b0, 5,
                 32'h0000_0040, 128'h40000003_40000002_40000001_40000000};

    rst_n = 1'b0;
    bus.miss_req  = 1'b0;
    bus.miss_addr = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst mem_req", bus.mem_req, 1'b0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst line_valid", bus.line_valid, 1'b0);
    chk("rst err", bus.err, 1'b0);
    chk("rst line_addr", bus.line_addr, 32'h0);
    chk("rst data_line", bus.data_line, 128'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Stray acks while idle must not disturb anything.
    stray_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stray busy", bus.busy, 1'b0);
      chk("stray mem_req", bus.mem_req, 1'b0);
      chk("stray pulses", {bus.line_valid, bus.err}, 2'b00);
      chk("stray line_addr", bus.line_addr, 32'hFFFF_FFF0);
      chk("stray data_line", bus.data_line, 128'h70000003_70000002_70000001_70000000);
    end
    stray_ack = 1'b0;

    // Async reset after two acknowledged words.
    @(negedge clk);
    seed = 32'h5500_0000; ack_period = 1; stall_en = 1'b0;
    exp_base = 32'h0000_0080; exp_k = 0;
    bus.miss_req = 1'b1; bus.miss_addr = 32'h0000_0080;
    @(negedge clk);
    bus.miss_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst mem_req", bus.mem_req, 1'b0);
    chk("midrst mem_addr", bus.mem_addr, 32'h0);
    chk("midrst pulses", {bus.line_valid, bus.err}, 2'b00);
    chk("midrst line_addr", bus.line_addr, 32'h0);
    chk("midrst data_line", bus.data_line, 128'h0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst held line_valid", bus.line_valid, 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_rst line_valid", bus.line_valid, 1'b0);
    run_vec(post_rst);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
